// File: rtl/lut_func_seq.sv
// N-input Boolean function unit backed by a serially loadable 2^N-bit truth table.
// Serves single registered lookups and an autonomous sweep over every input combination.
module lut_func_seq #(
  parameter int              N    = 3,
  parameter logic [2**N-1:0] INIT = 8'hFB
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [N-1:0] in_vec,
  input  logic         sweep_start,
  input  logic         cfg_we,
  input  logic         cfg_bit,
  output logic         cfg_ready,
  output logic         cfg_done,
  output logic         busy,
  output logic         out_valid,
  output logic [N-1:0] out_idx,
  output logic         out_z,
  output logic         sweep_done
);

  localparam int             W        = 2**N;
  localparam logic [N:0]     CNT_LAST = (N+1)'(W-1);
  localparam logic [N:0]     CNT_ONE  = (N+1)'(1);
  localparam logic [N-1:0]   IDX_LAST = {N{1'b1}};
  localparam logic [N-1:0]   IDX_ONE  = (N)'(1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  state_t         state_q,      state_d;
  logic [W-1:0]   table_q,      table_d;
  logic [W-1:0]   shadow_q,     shadow_d;
  logic [N:0]     cnt_q,        cnt_d;
  logic           out_valid_q,  out_valid_d;
  logic [N-1:0]   out_idx_q,    out_idx_d;
  logic           out_z_q,      out_z_d;
  logic           busy_q,       busy_d;
  logic           cfg_done_q,   cfg_done_d;
  logic           sweep_done_q, sweep_done_d;

  // Next-state, table load and result generation.
  always_comb begin
    state_d      = state_q;
    table_d      = table_q;
    shadow_d     = shadow_q;
    cnt_d        = cnt_q;
    out_valid_d  = 1'b0;
    out_idx_d    = out_idx_q;
    out_z_d      = out_z_q;
    busy_d       = busy_q;
    cfg_done_d   = 1'b0;
    sweep_done_d = 1'b0;

    case (state_q)
      IDLE: begin
        // Load is only accepted here, so cfg_ready (= ~busy) gates it for free.
        if (cfg_we) begin
          shadow_d = {shadow_q[W-2:0], cfg_bit};
          if (cnt_q == CNT_LAST) begin
            table_d    = shadow_d;
            cnt_d      = '0;
            cfg_done_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          shadow_d = shadow_q;
        end

        // A sweep runs entirely on the table in force after this cycle's commit.
        if (sweep_start) begin
          state_d     = SWEEP;
          busy_d      = 1'b1;
          out_valid_d = 1'b1;
          out_idx_d   = '0;
          out_z_d     = table_d[0];
        end else if (in_valid) begin
          out_valid_d = 1'b1;
          out_idx_d   = in_vec;
          out_z_d     = table_q[in_vec];
        end else begin
          out_valid_d = 1'b0;
        end
      end

      SWEEP: begin
        if (out_idx_q == IDX_LAST) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          out_valid_d  = 1'b1;
          out_idx_d    = out_idx_q + IDX_ONE;
          out_z_d      = table_q[out_idx_d];
          sweep_done_d = (out_idx_d == IDX_LAST);
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      table_q      <= INIT;
      shadow_q     <= '0;
      cnt_q        <= '0;
      out_valid_q  <= 1'b0;
      out_idx_q    <= '0;
      out_z_q      <= 1'b0;
      busy_q       <= 1'b0;
      cfg_done_q   <= 1'b0;
      sweep_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      table_q      <= table_d;
      shadow_q     <= shadow_d;
      cnt_q        <= cnt_d;
      out_valid_q  <= out_valid_d;
      out_idx_q    <= out_idx_d;
      out_z_q      <= out_z_d;
      busy_q       <= busy_d;
      cfg_done_q   <= cfg_done_d;
      sweep_done_q <= sweep_done_d;
    end
  end

  assign cfg_ready  = ~busy_q;
  assign cfg_done   = cfg_done_q;
  assign busy       = busy_q;
  assign out_valid  = out_valid_q;
  assign out_idx    = out_idx_q;
  assign out_z      = out_z_q;
  assign sweep_done = sweep_done_q;

endmodule

// File: tb/tb_lut_func_seq.sv
// Self-checking bench for lut_func_seq (N=3): directed scenarios plus randomized traffic
// compared against a truth-table array model.
module tb_lut_func_seq;

  localparam bit [7:0] INIT_T = 8'hFB;

  logic       clk = 1'b0;
  logic       rst, in_valid, sweep_start, cfg_we, cfg_bit;
  logic [2:0] in_vec;
  logic       cfg_ready, cfg_done, busy, out_valid, out_z, sweep_done;
  logic [2:0] out_idx;

  int checks = 0;
  int errors = 0;

  bit [7:0]   m_table;
  bit [7:0]   m_shadow;
  int         m_cnt;
  logic [2:0] m_idx;
  logic       m_z;

  lut_func_seq #(.N(3), .INIT(8'hFB)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_vec(in_vec),
    .sweep_start(sweep_start), .cfg_we(cfg_we), .cfg_bit(cfg_bit),
    .cfg_ready(cfg_ready), .cfg_done(cfg_done), .busy(busy),
    .out_valid(out_valid), .out_idx(out_idx), .out_z(out_z),
    .sweep_done(sweep_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    in_valid = 1'b0; in_vec = 3'd0; sweep_start = 1'b0; cfg_we = 1'b0; cfg_bit = 1'b0;
  endtask

  function automatic void model_reset();
    m_table = INIT_T; m_shadow = 8'h00; m_cnt = 0; m_idx = 3'd0; m_z = 1'b0;
  endfunction

  // Returns 1 when this bit completes a table.
  function automatic bit model_shift(input bit b);
    m_shadow = {m_shadow[6:0], b};
    m_cnt++;
    if (m_cnt == 8) begin
      m_table = m_shadow;
      m_cnt = 0;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic test_reset();
    logic [8:0] got, exp;
    clear_inputs();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    model_reset();
    got = {out_valid, out_idx, out_z, busy, cfg_done, sweep_done, cfg_ready};
    exp = {1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL reset_state got=%b exp=%b", got, exp);
    end
  endtask

  // Full sweep; with_junk also asserts in_valid with sweep_start and hammers inputs during it.
  task automatic test_sweep(input bit with_junk);
    logic [7:0] got, exp;
    int busy_cycles = 0;
    sweep_start = 1'b1;
    in_valid    = with_junk;
    in_vec      = 3'($urandom);
    tick();
    clear_inputs();
    for (int k = 0; k < 8; k++) begin
      got = {out_valid, out_idx, out_z, busy, sweep_done, cfg_ready};
      exp = {1'b1, 3'(k), m_table[k], 1'b1, (k == 7), 1'b0};
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL sweep_step%0d got=%b exp=%b", k, got, exp);
      end
      busy_cycles += int'(busy);
      if (with_junk) begin
        cfg_we = 1'b1; cfg_bit = 1'($urandom);
        in_valid = 1'b1; in_vec = 3'($urandom); sweep_start = 1'($urandom);
      end
      tick();
    end
    clear_inputs();
    m_idx = 3'd7; m_z = m_table[7];
    got = {out_valid, out_idx, out_z, busy, sweep_done, cfg_ready};
    exp = {1'b0, m_idx, m_z, 1'b0, 1'b0, 1'b1};
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL sweep_end got=%b exp=%b", got, exp);
    end
    checks++;
    if (busy_cycles !== 8) begin
      errors++; $display("FAIL sweep_busy_len got=%0d exp=8", busy_cycles);
    end
  endtask

  task automatic test_eval_pair();
    logic [5:0] got, exp;
    logic [2:0] vecs [2] = '{3'b010, 3'b110};
    logic       zs   [2] = '{1'b0, 1'b1};
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_vec = vecs[i];
      tick();
      m_idx = vecs[i]; m_z = zs[i];
      got = {out_valid, out_idx, out_z, cfg_done};
      exp = {1'b1, m_idx, m_z, 1'b0};
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL eval_b2b%0d got=%b exp=%b", i, got, exp);
      end
    end
    clear_inputs();
    tick();
    checks++;
    if ({out_valid, out_idx, out_z} !== {1'b0, m_idx, m_z}) begin
      errors++; $display("FAIL eval_hold got=%b exp=%b", {out_valid, out_idx, out_z}, {1'b0, m_idx, m_z});
    end
  endtask

  // Shifts a full table; cfg_done must pulse only after the last bit.
  task automatic test_load(input bit [7:0] value);
    bit exp_done;
    int dones = 0;
    for (int i = 7; i >= 0; i--) begin
      cfg_we = 1'b1; cfg_bit = value[i];
      exp_done = model_shift(value[i]);
      tick();
      dones += int'(cfg_done);
      checks++;
      if (cfg_done !== exp_done) begin
        errors++; $display("FAIL load_done_bit%0d got=%b exp=%b", 7 - i, cfg_done, exp_done);
      end
    end
    clear_inputs();
    tick();
    checks++;
    if (cfg_done !== 1'b0 || dones !== 1) begin
      errors++; $display("FAIL load_pulse got=%b/%0d exp=0/1", cfg_done, dones);
    end
  endtask

  task automatic test_partial_load();
    bit [7:0] value = 8'h96;
    bit [7:0] pre;
    bit       exp_done;
    logic [5:0] got, exp;
    rst = 1'b1; tick(); rst = 1'b0; model_reset();
    for (int i = 7; i >= 3; i--) begin
      cfg_we = 1'b1; cfg_bit = value[i];
      exp_done = model_shift(value[i]);
      tick();
    end
    clear_inputs();
    in_valid = 1'b1; in_vec = 3'b010;
    tick();
    got = {out_valid, out_idx, out_z, cfg_done};
    exp = {1'b1, 3'b010, 1'b0, 1'b0};
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL partial_keeps_init got=%b exp=%b", got, exp);
    end
    for (int i = 2; i >= 0; i--) begin
      pre = m_table;
      cfg_we = 1'b1; cfg_bit = value[i];
      in_valid = (i == 0); in_vec = 3'b010;
      exp_done = model_shift(value[i]);
      tick();
      if (i == 0) begin
        got = {out_valid, out_idx, out_z, cfg_done};
        exp = {1'b1, 3'b010, pre[2], exp_done};
        checks++;
        if (got !== exp) begin
          errors++; $display("FAIL commit_same_cycle_eval got=%b exp=%b", got, exp);
        end
      end
    end
    clear_inputs();
    in_valid = 1'b1; in_vec = 3'b010;
    tick();
    clear_inputs();
    m_idx = 3'b010; m_z = m_table[2];
    got = {out_valid, out_idx, out_z, cfg_done};
    exp = {1'b1, 3'b010, 1'b1, 1'b0};
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL post_commit_eval got=%b exp=%b", got, exp);
    end
  endtask

  task automatic test_reset_mid_sweep();
    bit [7:0] junk = 8'hE1;
    bit       unused_done;
    logic [8:0] got, exp;
    test_load(8'h5A);
    for (int i = 7; i >= 5; i--) begin
      cfg_we = 1'b1; cfg_bit = junk[i];
      unused_done = model_shift(junk[i]);
      tick();
    end
    clear_inputs();
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    for (int k = 0; k <= 4; k++) begin
      checks++;
      if ({out_valid, out_idx, out_z} !== {1'b1, 3'(k), m_table[k]}) begin
        errors++; $display("FAIL pre_abort_step%0d got=%b exp=%b", k, {out_valid, out_idx, out_z}, {1'b1, 3'(k), m_table[k]});
      end
      if (k < 4) tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    for (int c = 0; c < 5; c++) begin
      got = {out_valid, out_idx, out_z, busy, cfg_done, sweep_done, cfg_ready};
      exp = {1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL abort_cycle%0d got=%b exp=%b", c, got, exp);
      end
      tick();
    end
    test_sweep(1'b0);
    test_load(8'h3C);
    test_sweep(1'b0);
  endtask

  task automatic test_random();
    bit [7:0] pre;
    bit       iv, we, b, exp_done;
    logic [2:0] vec;
    logic [6:0] got, exp;
    for (int n = 0; n < 300; n++) begin
      iv = 1'($urandom); we = 1'($urandom); b = 1'($urandom); vec = 3'($urandom);
      pre = m_table;
      exp_done = we ? model_shift(b) : 1'b0;
      if (iv) begin
        m_idx = vec; m_z = pre[vec];
      end
      in_valid = iv; in_vec = vec; cfg_we = we; cfg_bit = b;
      tick();
      got = {out_valid, out_idx, out_z, cfg_done, busy};
      exp = {iv, m_idx, m_z, exp_done, 1'b0};
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL random_cycle%0d got=%b exp=%b", n, got, exp);
      end
    end
    clear_inputs();
    tick();
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    model_reset();
    test_reset();
    test_sweep(1'b0);
    test_eval_pair();
    test_load(8'h96);
    test_sweep(1'b0);
    test_partial_load();
    test_sweep(1'b1);
    test_load(8'hA5);
    test_sweep(1'b0);
    test_reset_mid_sweep();
    test_random();
    test_sweep(1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
